draw_sprite: RTL and testbench

//  Parametrised sprite overlay stage for the VGA pipeline. Takes the timing bus and

---
 rtl/draw_sprite.sv | 157 +++++++++++++++
 tb/tb_draw_sprite.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_sprite.sv
// Sprite overlay stage: draws a ROM bitmap over the background at a frame-latched position.
// Ports: pclk/rst; xpos/ypos/mirror/enable request; timing bus + rgb_in in; rom_addr/rom_data; delayed timing bus + rgb_out.
module draw_sprite #(
    parameter int          SPR_W     = 48,
    parameter int          SPR_H     = 64,
    parameter int          ADDR_XW   = 6,
    parameter int          ADDR_YW   = 6,
    parameter int          ROM_LAT   = 1,
    parameter int          KEY_EN    = 1,
    parameter logic [11:0] KEY_COLOR = 12'hF0F
) (
    input  logic                       pclk,
    input  logic                       rst,
    input  logic [11:0]                xpos,
    input  logic [11:0]                ypos,
    input  logic                       mirror,
    input  logic                       enable,
    input  logic [10:0]                hcount_in,
    input  logic [10:0]                vcount_in,
    input  logic                       hsync_in,
    input  logic                       vsync_in,
    input  logic                       hblnk_in,
    input  logic                       vblnk_in,
    input  logic [11:0]                rgb_in,
    output logic [ADDR_XW+ADDR_YW-1:0] rom_addr,
    input  logic [11:0]                rom_data,
    output logic [10:0]                hcount_out,
    output logic [10:0]                vcount_out,
    output logic                       hsync_out,
    output logic                       vsync_out,
    output logic                       hblnk_out,
    output logic                       vblnk_out,
    output logic [11:0]                rgb_out
);

    localparam int L  = ROM_LAT + 2;
    localparam int D  = ROM_LAT + 1;
    localparam int TW = 26;
    localparam int AW = ADDR_XW + ADDR_YW;

    // Frame-latched sprite request
    logic        vs_prev_q;
    logic [11:0] x_l_q, y_l_q;
    logic        mir_l_q, en_l_q;
    logic        vs_rise;

    assign vs_rise = vsync_in && !vs_prev_q;

    always_ff @(posedge pclk) begin
        if (rst) begin
            vs_prev_q <= 1'b0;
            x_l_q     <= '0;
            y_l_q     <= '0;
            mir_l_q   <= 1'b0;
            en_l_q    <= 1'b0;
        end else begin
            vs_prev_q <= vsync_in;
            if (vs_rise) begin
                x_l_q   <= xpos;
                y_l_q   <= ypos;
                mir_l_q <= mirror;
                en_l_q  <= enable;
            end
        end
    end

    // Hit test and address; 13 bits so a box past the counter range clips
    logic [12:0]   h13, v13, x_lo, x_hi, y_lo, y_hi, dx, dy, col;
    logic          hit;
    logic [AW-1:0] rom_addr_d, rom_addr_q;

    always_comb begin
        h13  = {2'b00, hcount_in};
        v13  = {2'b00, vcount_in};
        x_lo = {1'b0, x_l_q};
        y_lo = {1'b0, y_l_q};
        x_hi = x_lo + 13'(SPR_W);
        y_hi = y_lo + 13'(SPR_H);
        hit  = en_l_q && !hblnk_in && !vblnk_in
            && (h13 >= x_lo) && (h13 < x_hi)
            && (v13 >= y_lo) && (v13 < y_hi);
        dx   = h13 - x_lo;
        dy   = v13 - y_lo;
        col  = mir_l_q ? (13'(SPR_W - 1) - dx) : dx;
        rom_addr_d = '0;
        if (hit) begin
            rom_addr_d = {dy[ADDR_YW-1:0], col[ADDR_XW-1:0]};
        end
    end

    logic unused_bits;
    assign unused_bits = ^{dy[12:ADDR_YW], col[12:ADDR_XW]};

    always_ff @(posedge pclk) begin
        if (rst) begin
            rom_addr_q <= '0;
        end else begin
            rom_addr_q <= rom_addr_d;
        end
    end

    assign rom_addr = rom_addr_q;

    // Timing bus delayed by the full latency
    logic [TW-1:0] tpipe_q [L];
    // {hit, rgb_in} delayed to line up with rom_data
    logic [12:0]   dpipe_q [D];

    always_ff @(posedge pclk) begin
        if (rst) begin
            for (int i = 0; i < L; i++) begin
                tpipe_q[i] <= '0;
            end
            for (int i = 0; i < D; i++) begin
                dpipe_q[i] <= '0;
            end
        end else begin
            tpipe_q[0] <= {hcount_in, vcount_in, hsync_in,
                           vsync_in, hblnk_in, vblnk_in};
            for (int i = 1; i < L; i++) begin
                tpipe_q[i] <= tpipe_q[i-1];
            end
            dpipe_q[0] <= {hit, rgb_in};
            for (int i = 1; i < D; i++) begin
                dpipe_q[i] <= dpipe_q[i-1];
            end
        end
    end

    assign {hcount_out, vcount_out, hsync_out,
            vsync_out, hblnk_out, vblnk_out} = tpipe_q[L-1];

    // Composite: sprite pixel unless it matches the colour key
    logic        hit_d, keyed;
    logic [11:0] rgb_in_d, rgb_d, rgb_q;

    always_comb begin
        hit_d    = dpipe_q[D-1][12];
        rgb_in_d = dpipe_q[D-1][11:0];
        keyed    = (KEY_EN != 0) && (rom_data == KEY_COLOR);
        rgb_d    = rgb_in_d;
        if (hit_d && !keyed) begin
            rgb_d = rom_data;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign rgb_out = rgb_q;

endmodule

// File: tb/tb_draw_sprite.sv
// Bench for draw_sprite: three instances (ROM_LAT 1/0/2, colour key on/off)
// checked cycle by cycle against a scoreboard fed by a behavioural model.
module tb_draw_sprite;

    typedef struct packed {
        logic [10:0] hc;
        logic [10:0] vc;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
    } obs_t;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] xpos = '0, ypos = '0;
    logic        mirror = 1'b0, enable = 1'b0;
    logic [10:0] hcount_in = '0, vcount_in = '0;
    logic        hsync_in = 1'b0, vsync_in = 1'b0;
    logic        hblnk_in = 1'b0, vblnk_in = 1'b0;
    logic [11:0] rgb_in = '0;

    always #5 pclk = ~pclk;

    function automatic logic [11:0] rom_f(logic [11:0] a);
        return a ^ 12'h0A5;
    endfunction

    // Instance A: ROM_LAT=1, KEY_EN=1
    logic [11:0] addr_a, data_a = '0, rgb_a;
    logic [10:0] hc_a, vc_a;
    logic        hs_a, vs_a, hb_a, vb_a;
    always @(posedge pclk) data_a <= rom_f(addr_a);

    draw_sprite #(.ROM_LAT(1), .KEY_EN(1)) dut_a (
        .pclk(pclk), .rst(rst), .xpos(xpos), .ypos(ypos),
        .mirror(mirror), .enable(enable),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
        .rom_addr(addr_a), .rom_data(data_a),
        .hcount_out(hc_a), .vcount_out(vc_a),
        .hsync_out(hs_a), .vsync_out(vs_a),
        .hblnk_out(hb_a), .vblnk_out(vb_a), .rgb_out(rgb_a)
    );

    // Instance B: ROM_LAT=0, KEY_EN=0
    logic [11:0] addr_b, data_b, rgb_b;
    logic [10:0] hc_b, vc_b;
    logic        hs_b, vs_b, hb_b, vb_b;
    assign data_b = rom_f(addr_b);

    draw_sprite #(.ROM_LAT(0), .KEY_EN(0)) dut_b (
        .pclk(pclk), .rst(rst), .xpos(xpos), .ypos(ypos),
        .mirror(mirror), .enable(enable),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
        .rom_addr(addr_b), .rom_data(data_b),
        .hcount_out(hc_b), .vcount_out(vc_b),
        .hsync_out(hs_b), .vsync_out(vs_b),
        .hblnk_out(hb_b), .vblnk_out(vb_b), .rgb_out(rgb_b)
    );

    // Instance C: ROM_LAT=2, KEY_EN=1
    logic [11:0] addr_c, data_c1 = '0, data_c = '0, rgb_c;
    logic [10:0] hc_c, vc_c;
    logic        hs_c, vs_c, hb_c, vb_c;
    always @(posedge pclk) begin
        data_c1 <= rom_f(addr_c);
        data_c  <= data_c1;
    end

    draw_sprite #(.ROM_LAT(2), .KEY_EN(1)) dut_c (
        .pclk(pclk), .rst(rst), .xpos(xpos), .ypos(ypos),
        .mirror(mirror), .enable(enable),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
        .rom_addr(addr_c), .rom_data(data_c),
        .hcount_out(hc_c), .vcount_out(vc_c),
        .hsync_out(hs_c), .vsync_out(vs_c),
        .hblnk_out(hb_c), .vblnk_out(vb_c), .rgb_out(rgb_c)
    );

    int errors = 0;
    int checks = 0;

    obs_t qa[$], qb[$], qc[$];

    // Behavioural model of the latched request
    int   m_x = 0, m_y = 0;
    logic m_mir = 1'b0, m_en = 1'b0, m_vsp = 1'b0;

    function automatic logic [12:0] mdl(int h, int v, logic hb, logic vb);
        int c, r;
        if (!m_en || hb || vb) return 13'h0;
        if (h < m_x || h >= m_x + 48) return 13'h0;
        if (v < m_y || v >= m_y + 64) return 13'h0;
        c = h - m_x;
        if (m_mir) c = 47 - c;
        r = v - m_y;
        return {1'b1, 6'(r), 6'(c)};
    endfunction

    function automatic logic [11:0] mrgb(logic [12:0] ha,
                                         logic [11:0] bg, bit key);
        logic [11:0] p;
        p = rom_f(ha[11:0]);
        if (ha[12] && !(key && p == 12'hF0F)) return p;
        return bg;
    endfunction

    function automatic logic [11:0] bgc(int h, int v);
        return 12'(h * 7 + v * 13) ^ 12'h333;
    endfunction

    task automatic chk(input string tag, input logic [37:0] obs,
                       input logic [37:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input int h, input int v,
                        input logic hs, input logic vs,
                        input logic hb, input logic vb);
        obs_t        e;
        logic [12:0] ha;
        logic [11:0] ea;
        @(negedge pclk);
        rst       = r;
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hsync_in  = hs;
        vsync_in  = vs;
        hblnk_in  = hb;
        vblnk_in  = vb;
        rgb_in    = bgc(h, v);
        @(posedge pclk);
        if (r) begin
            qa.delete();
            qb.delete();
            qc.delete();
            repeat (3) qa.push_back('0);
            repeat (2) qb.push_back('0);
            repeat (4) qc.push_back('0);
            ea = '0;
            m_x = 0; m_y = 0; m_mir = 0; m_en = 0; m_vsp = 0;
        end else begin
            ha = mdl(h, v, hb, vb);
            ea = ha[11:0];
            e.hc = 11'(h);
            e.vc = 11'(v);
            e.hs = hs;
            e.vs = vs;
            e.hb = hb;
            e.vb = vb;
            e.rgb = mrgb(ha, bgc(h, v), 1'b1);
            qa.push_back(e);
            qc.push_back(e);
            e.rgb = mrgb(ha, bgc(h, v), 1'b0);
            qb.push_back(e);
            if (vs && !m_vsp) begin
                m_x = int'(xpos);
                m_y = int'(ypos);
                m_mir = mirror;
                m_en = enable;
            end
            m_vsp = vs;
        end
        #1;
        chk("addr_a", 38'(addr_a), 38'(ea));
        chk("addr_b", 38'(addr_b), 38'(ea));
        chk("addr_c", 38'(addr_c), 38'(ea));
        if (qa.size() >= 3) begin
            e = qa.pop_front();
            chk("out_a", {hc_a, vc_a, hs_a, vs_a, hb_a, vb_a, rgb_a}, e);
        end
        if (qb.size() >= 2) begin
            e = qb.pop_front();
            chk("out_b", {hc_b, vc_b, hs_b, vs_b, hb_b, vb_b, rgb_b}, e);
        end
        if (qc.size() >= 4) begin
            e = qc.pop_front();
            chk("out_c", {hc_c, vc_c, hs_c, vs_c, hb_c, vb_c, rgb_c}, e);
        end
    endtask

    task automatic scan(input int v, input int h0, input int h1,
                        input logic hb);
        for (int h = h0; h <= h1; h++) begin
            step(1'b0, h, v, 1'(h % 7 == 0), 1'b0, hb, 1'b0);
        end
    endtask

    task automatic vpulse();
        step(1'b0, 0, 600, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1, 600, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        repeat (3) step(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_rgb", 38'(rgb_a), 38'h0);

        // Enabled frame at (100,50) before any capture: hidden
        xpos = 12'd100; ypos = 12'd50; enable = 1'b1; mirror = 1'b0;
        scan(60, 98, 102, 1'b0);
        vpulse();

        // Corner addresses and full edge rows
        step(1'b0, 100, 50, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("addr_tl", 38'(addr_a), 38'h000);
        step(1'b0, 147, 113, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("addr_br", 38'(addr_a), 38'hFEF);
        scan(49, 95, 150, 1'b0);
        scan(50, 95, 150, 1'b0);
        scan(112, 138, 146, 1'b0);
        scan(113, 95, 150, 1'b0);
        scan(114, 95, 150, 1'b0);

        // Horizontal mirror
        mirror = 1'b1;
        vpulse();
        step(1'b0, 100, 50, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mir_l", 38'(addr_a), 38'h02F);
        step(1'b0, 147, 50, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mir_r", 38'(addr_a), 38'h000);
        scan(70, 95, 150, 1'b0);

        // Mid-frame move takes effect only on the next capture
        mirror = 1'b0;
        vpulse();
        scan(60, 95, 150, 1'b0);
        xpos = 12'd300;
        scan(61, 95, 150, 1'b0);
        scan(61, 295, 350, 1'b0);
        vpulse();
        scan(61, 95, 150, 1'b0);
        scan(61, 295, 350, 1'b0);

        // Right-edge clipping and blanking inside the box
        xpos = 12'd1000;
        vpulse();
        scan(60, 990, 1055, 1'b0);
        scan(61, 0, 50, 1'b0);
        scan(62, 1005, 1015, 1'b1);
        step(1'b0, 1010, 63, 1'b0, 1'b0, 1'b0, 1'b1);
        xpos = 12'd1040;
        vpulse();
        scan(60, 1035, 1055, 1'b0);
        scan(61, 0, 45, 1'b0);

        // Reset mid-sprite, then hidden until a capture
        xpos = 12'd100;
        vpulse();
        scan(60, 95, 120, 1'b0);
        step(1'b1, 121, 60, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_mid_rgb", 38'(rgb_a), 38'h0);
        chk("rst_mid_addr", 38'(addr_a), 38'h0);
        scan(60, 122, 150, 1'b0);
        scan(61, 95, 150, 1'b0);
        vpulse();
        scan(62, 95, 150, 1'b0);
        scan(63, 95, 100, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
